// File: rtl/command_controller.sv
// rtl/command_controller.sv - frame decoder producing one-cycle register read/write strobes
// Optional error pulse output: define CMDCTRL_ERR_EN.
module command_controller #(
    parameter int                    WORD_WIDTH  = 8,
    parameter int                    VALUE_WORDS = 4,
    parameter logic [WORD_WIDTH-1:0] READ_CMD    = 8'h00,
    parameter logic [WORD_WIDTH-1:0] WRITE_CMD   = 8'hAA
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic [WORD_WIDTH*(VALUE_WORDS+2)-1:0] i_data,
    input  logic                              i_dv,
    output logic [WORD_WIDTH-1:0]             o_w_addr,
    output logic [WORD_WIDTH*VALUE_WORDS-1:0] o_w_data,
    output logic                              o_w_en,
    output logic [WORD_WIDTH-1:0]             o_r_addr,
`ifdef CMDCTRL_ERR_EN
    output logic                              o_err,
`endif
    output logic                              o_r_en
);

    localparam int VAL_W   = WORD_WIDTH * VALUE_WORDS;
    localparam int FRAME_W = WORD_WIDTH * (VALUE_WORDS + 2);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]            state;
    logic [WORD_WIDTH-1:0] cmd;
    logic [WORD_WIDTH-1:0] addr;
    logic [VAL_W-1:0]      value;
    logic                  is_write;
    logic                  is_read;
    logic                  is_bad;

    assign cmd      = i_data[FRAME_W-1 -: WORD_WIDTH];
    assign addr     = i_data[VAL_W +: WORD_WIDTH];
    assign value    = i_data[VAL_W-1:0];
    assign is_write = i_dv && (cmd == WRITE_CMD);
    assign is_read  = i_dv && (cmd == READ_CMD) && !is_write;
    assign is_bad   = i_dv && !is_write && !is_read;

    // Strobes default low every edge so each accepted frame gives exactly one pulse.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state    <= IDLE;
            o_w_addr <= '0;
            o_w_data <= '0;
            o_w_en   <= 1'b0;
            o_r_addr <= '0;
            o_r_en   <= 1'b0;
        end else begin
            o_w_en <= 1'b0;
            o_r_en <= 1'b0;
            state  <= (is_write || is_read) ? ISSUE : IDLE;
            if (is_write) begin
                o_w_addr <= addr;
                o_w_data <= value;
                o_w_en   <= 1'b1;
            end else if (is_read) begin
                o_r_addr <= addr;
                o_r_en   <= 1'b1;
            end
        end
    end

`ifdef CMDCTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_err <= 1'b0;
        end else begin
            o_err <= is_bad;
        end
    end
`else
    logic unused_bad;
    assign unused_bad = is_bad;
`endif

    logic unused_state;
    assign unused_state = state[0];

endmodule

// File: tb/tb_command_controller.sv
// tb/tb_command_controller.sv - vector table plus scoreboard bench for command_controller
module tb_command_controller;

    logic        clk;
    logic        i_reset;
    logic [47:0] i_data;
    logic        i_dv;
    logic [7:0]  o_w_addr;
    logic [31:0] o_w_data;
    logic        o_w_en;
    logic [7:0]  o_r_addr;
    logic        o_r_en;
`ifdef CMDCTRL_ERR_EN
    logic        o_err;
`endif

    command_controller dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_data   (i_data),
        .i_dv     (i_dv),
        .o_w_addr (o_w_addr),
        .o_w_data (o_w_data),
        .o_w_en   (o_w_en),
        .o_r_addr (o_r_addr),
`ifdef CMDCTRL_ERR_EN
        .o_err    (o_err),
`endif
        .o_r_en   (o_r_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [47:0] data;
        logic        w_en;
        logic [7:0]  w_addr;
        logic [31:0] w_data;
        logic        r_en;
        logic [7:0]  r_addr;
        logic        err;
    } vec_t;

    vec_t vecs[17];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic rst, logic dv, logic [47:0] data, logic w_en,
                                logic [7:0] w_addr, logic [31:0] w_data, logic r_en,
                                logic [7:0] r_addr, logic err);
        vec_t v;
        v.rst = rst; v.dv = dv; v.data = data; v.w_en = w_en; v.w_addr = w_addr;
        v.w_data = w_data; v.r_en = r_en; v.r_addr = r_addr; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        i_reset = v.rst;
        i_dv    = v.dv;
        i_data  = v.data;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("w_en",   idx, {31'd0, o_w_en}, {31'd0, e.w_en});
        chk("w_addr", idx, {24'd0, o_w_addr}, {24'd0, e.w_addr});
        chk("w_data", idx, o_w_data, e.w_data);
        chk("r_en",   idx, {31'd0, o_r_en}, {31'd0, e.r_en});
        chk("r_addr", idx, {24'd0, o_r_addr}, {24'd0, e.r_addr});
        chk("strobe_excl", idx, {31'd0, o_w_en & o_r_en}, 32'd0);
`ifdef CMDCTRL_ERR_EN
        chk("err", idx, {31'd0, o_err}, {31'd0, e.err});
`endif
    endtask

    initial begin
        i_reset = 1'b0;
        i_dv    = 1'b0;
        i_data  = '0;

        //           rst dv  data                w_en w_addr w_data        r_en r_addr err
        vecs[0]  = mk(1, 1, 48'hAA_21_87654321, 0, 8'h00, 32'h00000000, 0, 8'h00, 0);
        vecs[1]  = mk(0, 0, 48'hAA_21_87654321, 0, 8'h00, 32'h00000000, 0, 8'h00, 0);
        vecs[2]  = mk(0, 1, 48'h00_12_12345678, 0, 8'h00, 32'h00000000, 1, 8'h12, 0);
        vecs[3]  = mk(0, 0, 48'h00_12_12345678, 0, 8'h00, 32'h00000000, 0, 8'h12, 0);
        vecs[4]  = mk(0, 1, 48'hAA_21_87654321, 1, 8'h21, 32'h87654321, 0, 8'h12, 0);
        vecs[5]  = mk(0, 0, 48'h00_00_00000000, 0, 8'h21, 32'h87654321, 0, 8'h12, 0);
        vecs[6]  = mk(0, 1, 48'h55_33_DEADBEEF, 0, 8'h21, 32'h87654321, 0, 8'h12, 1);
        vecs[7]  = mk(0, 0, 48'h00_00_00000000, 0, 8'h21, 32'h87654321, 0, 8'h12, 0);
        vecs[8]  = mk(0, 1, 48'hAA_01_00000001, 1, 8'h01, 32'h00000001, 0, 8'h12, 0);
        vecs[9]  = mk(0, 1, 48'h00_02_FFFFFFFF, 0, 8'h01, 32'h00000001, 1, 8'h02, 0);
        vecs[10] = mk(0, 0, 48'h00_02_FFFFFFFF, 0, 8'h01, 32'h00000001, 0, 8'h02, 0);
        vecs[11] = mk(0, 1, 48'h00_03_00000000, 0, 8'h01, 32'h00000001, 1, 8'h03, 0);
        vecs[12] = mk(0, 1, 48'h00_03_00000000, 0, 8'h01, 32'h00000001, 1, 8'h03, 0);
        vecs[13] = mk(0, 1, 48'hAA_44_CAFEF00D, 1, 8'h44, 32'hCAFEF00D, 0, 8'h03, 0);
        vecs[14] = mk(1, 0, 48'h00_00_00000000, 0, 8'h00, 32'h00000000, 0, 8'h00, 0);
        vecs[15] = mk(0, 0, 48'h00_00_00000000, 0, 8'h00, 32'h00000000, 0, 8'h00, 0);
        vecs[16] = mk(0, 0, 48'hAA_55_11111111, 0, 8'h00, 32'h00000000, 0, 8'h00, 0);

        for (int i = 0; i < 17; i++) begin
            // Twenty idle cycles between the read and the write: read address must hold.
            if (i == 4) begin
                for (int k = 0; k < 20; k++)
                    step(mk(0, 0, 48'h0, 0, 8'h00, 32'h0, 0, 8'h12, 0), 100 + k);
            end
            step(vecs[i], i);
        end

        // Write followed immediately by reset in its strobe cycle.
        step(mk(0, 1, 48'hAA_77_A5A5A5A5, 1, 8'h77, 32'hA5A5A5A5, 0, 8'h00, 0), 200);
        step(mk(1, 1, 48'hAA_77_A5A5A5A5, 0, 8'h00, 32'h00000000, 0, 8'h00, 0), 201);
        step(mk(0, 0, 48'h0, 0, 8'h00, 32'h0, 0, 8'h00, 0), 202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/command_controller.md
Name: command_controller

Overview:
Decodes fixed-width command frames from an upstream receiver (e.g. a UART/SPI word assembler) into single-cycle register-file read or write strobes. A frame is {command word, address word, value words}, presented in parallel with a one-cycle valid. It sits between the host-link frame assembler and the register bank. Outputs are registered, and each accepted command yields exactly one strobe.

Parameters:
WORD_WIDTH, 8, bit width of the command word and the address word.
VALUE_WORDS, 4, number of WORD_WIDTH words in the value field; the value is WORD_WIDTH*VALUE_WORDS bits.
READ_CMD, 8'h00, command code for a read; width WORD_WIDTH.
WRITE_CMD, 8'hAA, command code for a write; width WORD_WIDTH.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_data  in  WORD_WIDTH*(VALUE_WORDS+2)  frame: [MSB word]=command, next word=address, low WORD_WIDTH*VALUE_WORDS bits=value (MSB-first).
i_dv  in  1  frame valid; i_data is sampled on any edge where i_dv=1.
o_w_addr  out  WORD_WIDTH  write address.
o_w_data  out  WORD_WIDTH*VALUE_WORDS  write data.
o_w_en  out  1  write strobe, one cycle per accepted write.
o_r_addr  out  WORD_WIDTH  read address.
o_r_en  out  1  read strobe, one cycle per accepted read.

Behaviour:
- Reset: on an edge with i_reset=1, all outputs go to 0. Reset has priority over i_dv; a frame presented in the reset cycle is discarded.
- Field split: cmd = i_data[top WORD_WIDTH bits]; addr = next WORD_WIDTH bits; value = remaining low bits.
- Latency: 1 cycle. A frame sampled at edge N drives its strobe high for the cycle after edge N. The strobe drops at edge N+1 unless another command is accepted there.
- cmd==WRITE_CMD: o_w_addr<=addr, o_w_data<=value, o_w_en<=1. The read outputs are unchanged except o_r_en<=0.
- cmd==READ_CMD: o_r_addr<=addr, o_r_en<=1. The value field is ignored. o_w_addr and o_w_data are unchanged, and o_w_en<=0.
- Any other cmd: no strobe and no address or data change; the frame is dropped.
- Address and data outputs hold their last loaded value until the next accepted command of the same type.
- o_w_en and o_r_en are never high in the same cycle.
- i_dv=0: both strobes are 0 on the next cycle.
- Back-to-back: each cycle with i_dv=1 is an independent frame. There is no busy or back-pressure; a frame every cycle produces a strobe every cycle.
- i_dv held high for k cycles with constant i_data produces k strobes. Upstream must pulse i_dv for one cycle per frame.
- Implementation uses a registered decode stage (IDLE/ISSUE view: ISSUE is the one-cycle strobe state, returning to IDLE or re-entering ISSUE on a new i_dv).

Optional Feature:
Macro CMDCTRL_ERR_EN.
- Defined: adds output o_err (1 bit, reset 0). It pulses high for one cycle, with the same 1-cycle latency, when an accepted frame carries a command that is neither READ_CMD nor WRITE_CMD.
- Undefined: the port does not exist, and unknown commands are silently dropped.

Test Plan:
1. Assert i_reset for 1 cycle -> all outputs 0; i_dv=1 with a WRITE frame during reset produces no o_w_en afterwards.
2. Read frame {00,12,12345678} with a 1-cycle i_dv -> next cycle o_r_en=1, o_r_addr=0x12, o_w_en=0, o_w_data still 0; one cycle later o_r_en=0 and o_r_addr holds 0x12.
3. Read frame, 20 idle cycles, then write frame {AA,21,87654321} -> next cycle o_w_en=1 for exactly one cycle, o_w_addr=0x21, o_w_data=0x87654321; o_r_addr stays 0x12.
4. Frame {55,33,DEADBEEF} -> no strobe, and all address/data outputs unchanged; with CMDCTRL_ERR_EN, o_err=1 for one cycle.
5. Write {AA,01,00000001} then read {00,02,x} on consecutive cycles -> o_w_en then o_r_en on consecutive cycles, never simultaneous.
6. Write frame with i_reset=1 in the strobe cycle -> o_w_en, o_w_addr and o_w_data all cleared to 0 on the following edge.
